pci32_cfg_enumerator: RTL and testbench
=======================================

Name: pci32_cfg_enumerator

Overview:
Configuration-space initiator that scans bus 0 for function-0 devices and reads each vendor/device ID. For every present device it sizes BAR0..BAR2 by writing all-ones and reading back the mask. It assigns each memory BAR a naturally aligned base from a linear allocator, then enables the device through its command register. It sits between the boot/host control logic and the cs_config bus of the pci32 configuration targets.

Parameters:
MAX_DEV, 32, number of device slots scanned (devices 0..MAX_DEV-1, function 0 only)
MEM_BASE, 32'h4000_0000, first address handed out by the allocator
MEM_LIMIT, 32'h7FFF_FFFF, last address that may be allocated (inclusive)
CMD_ENABLE, 16'h0006, command value written to enabled devices (memory space + bus master)
TIMEOUT, 255, ack watchdog limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse that begins a scan; ignored while busy_o=1
busy_o  out  1  scan in progress
done_o  out  1  one-cycle pulse when the scan finishes
err_o  out  1  sticky: allocation overflow or timeout in the last scan; cleared by start_i
dev_count_o  out  6  number of devices found in the last scan
next_addr_o  out  32  allocator pointer after the last scan
cs_config_o  out  1  config request strobe; held until ack_i
we_o  out  1  write when 1, read when 0
sel_o  out  4  byte lanes; always 4'hF except command write, which uses 4'h3
adr_o  out  32  {4'h0, bus[27:20]=0, dev[19:15], func[14:12]=0, 4'h0, reg[7:2], 2'b00}
dat_o  out  32  write data
dat_i  in  32  read data, valid in the ack_i cycle
ack_i  in  1  transaction complete

Behaviour:
- Reset (async, rst_ni=0): all outputs 0; next_addr_o=MEM_BASE; state IDLE; dev and BAR index 0.
- Bus handshake:
  - cs_config_o, we_o, sel_o, adr_o and dat_o are registered and stay stable until the first cycle ack_i=1 while cs_config_o=1.
  - cs_config_o drops in the cycle after ack. At least one idle cycle separates transactions.
  - ack_i with cs_config_o=0 is ignored.
- States:
  - IDLE: on start_i, clear err_o and dev_count_o, set next pointer to MEM_BASE, dev=0 -> RD_ID.
  - RD_ID: read reg 0. If dat_i[15:0]==16'hFFFF, the slot is empty -> NEXT_DEV. Otherwise increment dev_count and set bar=0 -> WR_ONES.
  - WR_ONES: write 32'hFFFF_FFFF to reg 4+bar -> RD_MASK.
  - RD_MASK: latch the mask.
    - mask==0 (BAR not implemented) or mask[0]==1 (I/O BAR): base=0 -> WR_BASE.
    - Otherwise -> ALLOC.
  - ALLOC (1 cycle), all arithmetic 33-bit unsigned:
    - size = ~(mask & 32'hFFFF_FFF0) + 1.
    - base = (next + size - 1) & ~(size - 1).
    - If base + size - 1 > MEM_LIMIT: set err_o and base=0; next is unchanged.
    - Otherwise next = base + size.
    - -> WR_BASE.
  - WR_BASE: write base to reg 4+bar. If bar<2, bar++ -> WR_ONES. Else -> WR_CMD.
  - WR_CMD: write reg 1 with sel_o=4'h3 and dat_o={16'h0,CMD_ENABLE}. If any BAR of this device failed allocation, write dat_o=16'h0004 instead (bus master only) -> NEXT_DEV.
  - NEXT_DEV: if dev==MAX_DEV-1 -> DONE. Else dev++ -> RD_ID.
  - DONE: pulse done_o for one cycle, drop busy_o, update dev_count_o and next_addr_o -> IDLE.
- busy_o is 1 in every state except IDLE. start_i while busy is ignored.
- Mask 32'hFFFF_FFF0 gives size 16. Mask 32'h0000_0000 is skipped. A size of 2^32 always overflows.
- Reset mid-scan aborts immediately, with no trailing transaction completion. The target may be left with the all-ones BAR value.

Optional Feature:
PCI32_CFG_ENUM_TIMEOUT_EN
- Defined:
  - An 8-bit counter runs while cs_config_o=1 and ack_i=0.
  - When the count reaches TIMEOUT, the transaction is aborted (cs_config_o drops) and the read returns 32'hFFFF_FFFF (master abort). err_o is set.
  - An RD_ID timeout therefore reads as an empty slot.
- Not defined: the initiator waits for ack_i indefinitely. No counter logic is present.

Test Plan:
1. Empty bus: all reads return 32'hFFFF_FFFF -> 32 ID reads, no writes, done_o pulse, dev_count_o=0, next_addr_o=32'h4000_0000, err_o=0.
2. Single device at dev 3, masks BAR0=FFFF_F000, BAR1=0, BAR2=FFF0_0000 -> expected transactions:
   - BAR0 written 4000_0000, BAR1 written 0, BAR2 written 4010_0000.
   - Cmd write 0006 with sel 3.
   - next_addr_o=4020_0000, dev_count_o=1.
3. Alignment: two devices, first BAR0 mask FFFF_FFF0, second BAR0 mask FFFF_0000 -> bases 4000_0000 and 4001_0000, next_addr_o=4002_0000.
4. Overflow: MEM_LIMIT=4000_0FFF, BAR0 mask FFFF_E000 -> BAR0 written 0, cmd written 0004, err_o=1 after done_o.
5. Handshake: ack_i delayed 5 cycles on each transaction -> adr_o, dat_o and we_o stay stable throughout. Then assert rst_ni=0 mid-WR_BASE -> all outputs 0 in the same cycle, busy_o=0.
6. (PCI32_CFG_ENUM_TIMEOUT_EN) Dev 0 never acks -> abort after 255 cycles, slot treated as empty, err_o=1, scan continues to dev 1.

Source files
------------

// File: rtl/pci32_cfg_enumerator.sv
// pci32_cfg_enumerator
// Bus-0 configuration scanner: probes function 0 of each device slot, sizes
// BAR0..BAR2, hands out naturally aligned memory bases from a linear
// allocator and finally enables each discovered device.
// Optional build macro: PCI32_CFG_ENUM_TIMEOUT_EN adds an ack watchdog that
// master-aborts a stalled transaction (read data forced to all ones).
module pci32_cfg_enumerator #(
  parameter int unsigned MAX_DEV    = 32,
  parameter logic [31:0] MEM_BASE   = 32'h4000_0000,
  parameter logic [31:0] MEM_LIMIT  = 32'h7FFF_FFFF,
  parameter logic [15:0] CMD_ENABLE = 16'h0006,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [5:0]  dev_count_o,
  output logic [31:0] next_addr_o,
  output logic        cs_config_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_ID,
    S_WR_ONES,
    S_RD_MASK,
    S_ALLOC,
    S_WR_BASE,
    S_WR_CMD,
    S_NEXT_DEV,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  dev_q, dev_d;
  logic [1:0]  bar_q, bar_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] base_q, base_d;
  logic [32:0] next_q, next_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        fail_q, fail_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [5:0]  dev_count_q, dev_count_d;
  logic [31:0] next_addr_q, next_addr_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;

  // Per-state bus request description
  logic        req_bus;
  logic        req_we;
  logic [5:0]  req_reg;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;

  // Transfer completion (ack, or watchdog abort when enabled)
  logic        xfer_done;
  logic        xfer_abort;
  logic [31:0] rdata;

  // Allocator datapath; extra headroom bits so that a 2^32 size or a base
  // rounded past 4 GiB can never wrap back under the limit.
  logic [33:0] alloc_size;
  logic [33:0] alloc_base;
  logic [33:0] alloc_end;
  logic [32:0] alloc_next;

  assign alloc_size = {2'b00, ~(mask_q & 32'hFFFF_FFF0)} + 34'd1;
  assign alloc_base = ({1'b0, next_q} + alloc_size - 34'd1) & ~(alloc_size - 34'd1);
  assign alloc_end  = alloc_base + alloc_size - 34'd1;
  assign alloc_next = alloc_base[32:0] + alloc_size[32:0];

`ifdef PCI32_CFG_ENUM_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       to_hit;

  assign to_hit = (to_cnt_q == 8'(TIMEOUT - 1));

  // Count cycles spent waiting for ack; restarts whenever the bus is idle or acks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (!cs_q || ack_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  assign xfer_done  = cs_q & (ack_i | to_hit);
  assign xfer_abort = cs_q & ~ack_i & to_hit;
  assign rdata      = ack_i ? dat_i : 32'hFFFF_FFFF;
`else
  assign xfer_done  = cs_q & ack_i;
  assign xfer_abort = 1'b0;
  assign rdata      = dat_i;
`endif

  // Decode which config transaction the current state needs
  always_comb begin
    req_bus = 1'b0;
    req_we  = 1'b0;
    req_reg = 6'd0;
    req_sel = 4'hF;
    req_dat = 32'h0;
    case (state_q)
      S_RD_ID: begin
        req_bus = 1'b1;
      end
      S_WR_ONES: begin
        req_bus = 1'b1;
        req_we  = 1'b1;
        req_reg = 6'd4 + {4'd0, bar_q};
        req_dat = 32'hFFFF_FFFF;
      end
      S_RD_MASK: begin
        req_bus = 1'b1;
        req_reg = 6'd4 + {4'd0, bar_q};
      end
      S_WR_BASE: begin
        req_bus = 1'b1;
        req_we  = 1'b1;
        req_reg = 6'd4 + {4'd0, bar_q};
        req_dat = base_q;
      end
      S_WR_CMD: begin
        // A device with an unplaced BAR must not decode memory space
        req_bus = 1'b1;
        req_we  = 1'b1;
        req_reg = 6'd1;
        req_sel = 4'h3;
        req_dat = {16'h0, fail_q ? 16'h0004 : CMD_ENABLE};
      end
      default: ;
    endcase
  end

  // Scan sequencer: next state, bus launch/retire and allocator updates
  always_comb begin
    state_d     = state_q;
    dev_d       = dev_q;
    bar_d       = bar_q;
    mask_d      = mask_q;
    base_d      = base_q;
    next_d      = next_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    err_d       = err_q;
    done_d      = 1'b0;
    dev_count_d = dev_count_q;
    next_addr_d = next_addr_q;
    cs_d        = cs_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;

    // Launch: every bus state enters with cs low (the idle cycle after the
    // previous ack), so a low cs inside a bus state means "not yet issued".
    if (req_bus && !cs_q) begin
      cs_d  = 1'b1;
      we_d  = req_we;
      sel_d = req_sel;
      adr_d = {4'h0, 8'h00, dev_q, 3'b000, 4'h0, req_reg, 2'b00};
      dat_d = req_dat;
    end

    if (xfer_done)  cs_d  = 1'b0;
    if (xfer_abort) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d       = 1'b0;
          dev_count_d = 6'd0;
          cnt_d       = 6'd0;
          next_d      = {1'b0, MEM_BASE};
          dev_d       = 5'd0;
          state_d     = S_RD_ID;
        end
      end
      S_RD_ID: begin
        if (xfer_done) begin
          if (rdata[15:0] == 16'hFFFF) begin
            state_d = S_NEXT_DEV;
          end else begin
            cnt_d   = cnt_q + 6'd1;
            bar_d   = 2'd0;
            fail_d  = 1'b0;
            state_d = S_WR_ONES;
          end
        end
      end
      S_WR_ONES: begin
        if (xfer_done) state_d = S_RD_MASK;
      end
      S_RD_MASK: begin
        if (xfer_done) begin
          mask_d = rdata;
          if (rdata == 32'h0 || rdata[0]) begin
            base_d  = 32'h0;
            state_d = S_WR_BASE;
          end else begin
            state_d = S_ALLOC;
          end
        end
      end
      S_ALLOC: begin
        if (alloc_end > {2'b00, MEM_LIMIT}) begin
          err_d  = 1'b1;
          fail_d = 1'b1;
          base_d = 32'h0;
        end else begin
          base_d = alloc_base[31:0];
          next_d = alloc_next;
        end
        state_d = S_WR_BASE;
      end
      S_WR_BASE: begin
        if (xfer_done) begin
          if (bar_q != 2'd2) begin
            bar_d   = bar_q + 2'd1;
            state_d = S_WR_ONES;
          end else begin
            state_d = S_WR_CMD;
          end
        end
      end
      S_WR_CMD: begin
        if (xfer_done) state_d = S_NEXT_DEV;
      end
      S_NEXT_DEV: begin
        if (dev_q == 5'(MAX_DEV - 1)) begin
          state_d = S_DONE;
        end else begin
          dev_d   = dev_q + 5'd1;
          state_d = S_RD_ID;
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        dev_count_d = cnt_q;
        next_addr_d = next_q[31:0];
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      dev_q       <= '0;
      bar_q       <= '0;
      mask_q      <= '0;
      base_q      <= '0;
      next_q      <= {1'b0, MEM_BASE};
      cnt_q       <= '0;
      fail_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      dev_count_q <= '0;
      next_addr_q <= MEM_BASE;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      dev_q       <= dev_d;
      bar_q       <= bar_d;
      mask_q      <= mask_d;
      base_q      <= base_d;
      next_q      <= next_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
      done_q      <= done_d;
      dev_count_q <= dev_count_d;
      next_addr_q <= next_addr_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dev_count_o = dev_count_q;
  assign next_addr_o = next_addr_q;
  assign cs_config_o = cs_q;
  assign we_o        = we_q;
  assign sel_o       = sel_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;

endmodule

// File: tb/tb_pci32_cfg_enumerator.sv
// Bench for pci32_cfg_enumerator: a behavioural config-space target answers
// the bus and records every completed transaction; a reference model derives
// the expected transaction list and scan results from the device table.
`timescale 1ns/1ps
module tb_pci32_cfg_enumerator;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam longint      LIMIT = 64'h7FFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [5:0]  dev_count_o;
  logic [31:0] next_addr_o;
  logic        cs_config_o, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  pci32_cfg_enumerator dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .dev_count_o(dev_count_o),
    .next_addr_o(next_addr_o), .cs_config_o(cs_config_o), .we_o(we_o),
    .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Target configuration and state
  bit          present [32];
  logic [31:0] bmask [32][3];
  logic [31:0] barv [32][3];
  logic [15:0] cmdv [32];
  int          ack_delay = -1;
  int          mute_dev = -1;

  logic [47:0] log_q[$];
  logic [47:0] exp_q[$];
  int          stab_err = 0;
  int          gap_err = 0;
  int          exp_cnt;
  logic [31:0] exp_next;
  bit          exp_err;

  function automatic logic [47:0] txn(bit we, logic [3:0] sel, int dev, int r, logic [31:0] d);
    return {we, sel, 5'(dev), 6'(r), d};
  endfunction

  function automatic logic [31:0] rd_val(int d, int r);
    if (!present[d]) return 32'hFFFF_FFFF;
    case (r)
      0:       return {16'h1000 + 16'(d), 16'h10EE};
      1:       return {16'h0, cmdv[d]};
      4, 5, 6: return barv[d][r-4];
      default: return 32'h0;
    endcase
  endfunction

  // Config-space target: random or fixed ack latency, records completed
  // transactions, flags request changes while waiting and missing idle gaps.
  initial begin : responder
    bit          act;
    int          wcnt, dv, rg;
    logic [31:0] a0, d0;
    logic        w0;
    logic [3:0]  s0;
    act = 0; wcnt = 0; ack_i = 0; dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        ack_i = 0; dat_i = '0; act = 0;
      end else if (ack_i) begin
        ack_i = 0; dat_i = '0;
        if (cs_config_o) gap_err++;
      end else if (!cs_config_o) begin
        act = 0;
      end else begin
        if (!act) begin
          act = 1; a0 = adr_o; d0 = dat_o; w0 = we_o; s0 = sel_o;
          wcnt = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
        end else if (adr_o !== a0 || dat_o !== d0 || we_o !== w0 || sel_o !== s0) begin
          stab_err++;
        end
        dv = int'(a0[19:15]);
        rg = int'(a0[7:2]);
        if (dv != mute_dev) begin
          if (wcnt > 0) begin
            wcnt--;
          end else begin
            log_q.push_back(txn(w0, s0, dv, rg, w0 ? d0 : 32'h0));
            if (w0) begin
              if (rg >= 4 && rg <= 6) barv[dv][rg-4] = d0 & bmask[dv][rg-4];
              else if (rg == 1) cmdv[dv] = d0[15:0];
            end else begin
              dat_i = rd_val(dv, rg);
            end
            ack_i = 1;
            act = 0;
          end
        end
      end
    end
  end

  // Reference model: walks the slots in order and places memory BARs with
  // round-up division on a byte-address pointer.
  task automatic build_model();
    longint nxt, sz, bs, mm;
    bit fail;
    nxt = BASE;
    exp_q.delete(); exp_cnt = 0; exp_err = 0;
    for (int d = 0; d < 32; d++) begin
      if (d == mute_dev) begin exp_err = 1; continue; end
      exp_q.push_back(txn(0, 4'hF, d, 0, 32'h0));
      if (!present[d]) continue;
      exp_cnt++; fail = 0;
      for (int b = 0; b < 3; b++) begin
        exp_q.push_back(txn(1, 4'hF, d, 4 + b, 32'hFFFF_FFFF));
        exp_q.push_back(txn(0, 4'hF, d, 4 + b, 32'h0));
        bs = 0;
        if (bmask[d][b] != 32'h0 && !bmask[d][b][0]) begin
          mm = bmask[d][b] & 32'hFFFF_FFF0;
          sz = 64'h1_0000_0000 - mm;
          bs = ((nxt + sz - 1) / sz) * sz;
          if (bs + sz - 1 > LIMIT) begin exp_err = 1; fail = 1; bs = 0; end
          else nxt = bs + sz;
        end
        exp_q.push_back(txn(1, 4'hF, d, 4 + b, 32'(bs)));
      end
      exp_q.push_back(txn(1, 4'h3, d, 1, fail ? 32'h4 : 32'h6));
    end
    exp_next = 32'(nxt);
  endtask

  function automatic int first_diff();
    if (log_q.size() != exp_q.size()) return -2;
    foreach (log_q[i]) if (log_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic [47:0] log_at(int i);
    return (i >= 0 && i < log_q.size()) ? log_q[i] : 48'h0;
  endfunction

  function automatic logic [47:0] exp_at(int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 48'h0;
  endfunction

  task automatic clear_cfg();
    for (int d = 0; d < 32; d++) begin
      present[d] = 0; cmdv[d] = '0;
      for (int b = 0; b < 3; b++) begin bmask[d][b] = '0; barv[d][b] = '0; end
    end
    mute_dev = -1;
  endtask

  // Pulse start, optionally pulse it again mid-scan, wait (bounded) for done
  task automatic run_scan(input int extra_at, output bit got, output bit pulse_ok);
    log_q.delete(); stab_err = 0; gap_err = 0;
    for (int d = 0; d < 32; d++) begin
      cmdv[d] = '0;
      for (int b = 0; b < 3; b++) barv[d][b] = '0;
    end
    @(negedge clk_i); start_i = 1;
    @(negedge clk_i); start_i = 0;
    got = 0;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(negedge clk_i);
      got = done_o;
      start_i = (i == extra_at);
    end
    start_i = 0;
    @(negedge clk_i);
    pulse_ok = !done_o;
  endtask

  function automatic logic [31:0] pick_mask();
    logic [31:0] one;
    one = 32'h1;
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FF01;
      2: return ~((one << $urandom_range(4, 28)) - 32'h1);
      3: return ~((one << $urandom_range(4, 24)) - 32'h1) | 32'h8;
      4: return 32'hFFFF_FFF0;
      default: return 32'h8000_0000;
    endcase
  endfunction

  task automatic test_reset();
    rst_ni = 0; start_i = 0;
    repeat (3) @(negedge clk_i);
    total++;
    if ({cs_config_o, we_o, sel_o, adr_o, dat_o} !== '0) begin
      bad++; $display("FAIL reset_bus: got cs=%b we=%b sel=%h adr=%h dat=%h exp all 0",
                      cs_config_o, we_o, sel_o, adr_o, dat_o);
    end
    total++;
    if ({busy_o, done_o, err_o, dev_count_o} !== '0) begin
      bad++; $display("FAIL reset_status: got busy=%b done=%b err=%b cnt=%0d exp 0",
                      busy_o, done_o, err_o, dev_count_o);
    end
    total++;
    if (next_addr_o !== BASE) begin
      bad++; $display("FAIL reset_next: got=%h exp=%h", next_addr_o, BASE);
    end
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  task automatic test_empty_bus();
    bit got, pok; int d;
    clear_cfg(); build_model();
    run_scan(-1, got, pok);
    total++; if (!got) begin bad++; $display("FAIL empty_done: no done_o within budget"); end
    total++; if (!pok) begin bad++; $display("FAIL empty_done_width: done_o high for more than one cycle"); end
    total++; d = first_diff();
    if (d != -1) begin
      bad++; $display("FAIL empty_log: idx=%0d n=%0d exp_n=%0d got=%h exp=%h",
                      d, log_q.size(), exp_q.size(), log_at(d), exp_at(d));
    end
    total++;
    if (dev_count_o !== 6'(exp_cnt) || next_addr_o !== exp_next || err_o !== exp_err) begin
      bad++; $display("FAIL empty_result: got cnt=%0d next=%h err=%b exp cnt=%0d next=%h err=%b",
                      dev_count_o, next_addr_o, err_o, exp_cnt, exp_next, exp_err);
    end
    total++; if (gap_err != 0) begin bad++; $display("FAIL empty_gap: got=%0d exp=0", gap_err); end
  endtask

  task automatic test_single_dev();
    bit got, pok; int d;
    clear_cfg();
    present[3] = 1;
    bmask[3][0] = 32'hFFFF_F000; bmask[3][1] = 32'h0; bmask[3][2] = 32'hFFF0_0000;
    build_model();
    run_scan(-1, got, pok);
    total++; d = first_diff();
    if (!got || d != -1) begin
      bad++; $display("FAIL single_log: done=%b idx=%0d got=%h exp=%h", got, d, log_at(d), exp_at(d));
    end
    total++;
    if (next_addr_o !== 32'h4020_0000 || dev_count_o !== 6'd1 || err_o !== 1'b0) begin
      bad++; $display("FAIL single_result: got next=%h cnt=%0d err=%b exp next=40200000 cnt=1 err=0",
                      next_addr_o, dev_count_o, err_o);
    end
    total++;
    if (cmdv[3] !== 16'h0006) begin bad++; $display("FAIL single_cmd: got=%h exp=0006", cmdv[3]); end
  endtask

  task automatic test_alignment();
    bit got, pok; int d;
    clear_cfg();
    present[0] = 1; bmask[0][0] = 32'hFFFF_FFF0;
    present[1] = 1; bmask[1][0] = 32'hFFFF_0000;
    build_model();
    run_scan(-1, got, pok);
    total++; d = first_diff();
    if (!got || d != -1) begin
      bad++; $display("FAIL align_log: done=%b idx=%0d got=%h exp=%h", got, d, log_at(d), exp_at(d));
    end
    total++;
    if (next_addr_o !== 32'h4002_0000 || dev_count_o !== 6'd2) begin
      bad++; $display("FAIL align_result: got next=%h cnt=%0d exp next=40020000 cnt=2",
                      next_addr_o, dev_count_o);
    end
  endtask

  task automatic test_overflow();
    bit got, pok; int d;
    clear_cfg();
    present[0] = 1;
    bmask[0][0] = 32'hC000_0000; bmask[0][1] = 32'hFFFF_E000; bmask[0][2] = 32'h0000_0008;
    present[4] = 1; bmask[4][0] = 32'hFFFF_FFF0;
    build_model();
    run_scan(-1, got, pok);
    total++; d = first_diff();
    if (!got || d != -1) begin
      bad++; $display("FAIL ovf_log: done=%b idx=%0d got=%h exp=%h", got, d, log_at(d), exp_at(d));
    end
    total++;
    if (err_o !== 1'b1 || next_addr_o !== exp_next) begin
      bad++; $display("FAIL ovf_result: got err=%b next=%h exp err=1 next=%h", err_o, next_addr_o, exp_next);
    end
    total++;
    if (cmdv[0] !== 16'h0004 || cmdv[4] !== 16'h0004) begin
      bad++; $display("FAIL ovf_cmd: got %h/%h exp 0004/0004", cmdv[0], cmdv[4]);
    end
    // A clean follow-up scan must clear the sticky error
    clear_cfg(); present[7] = 1; bmask[7][1] = 32'hFFFF_FF00;
    run_scan(-1, got, pok);
    total++;
    if (!got || err_o !== 1'b0 || next_addr_o !== 32'h4000_0100) begin
      bad++; $display("FAIL ovf_clear: got done=%b err=%b next=%h exp done=1 err=0 next=40000100",
                      got, err_o, next_addr_o);
    end
  endtask

  task automatic test_random();
    bit got, pok; int d;
    for (int it = 0; it < 4; it++) begin
      clear_cfg();
      for (int s = 0; s < 32; s++) begin
        present[s] = ($urandom_range(0, 3) == 0);
        for (int b = 0; b < 3; b++) bmask[s][b] = pick_mask();
      end
      build_model();
      run_scan(-1, got, pok);
      total++; d = first_diff();
      if (!got || d != -1) begin
        bad++; $display("FAIL rand%0d_log: done=%b idx=%0d got=%h exp=%h", it, got, d, log_at(d), exp_at(d));
      end
      total++;
      if (dev_count_o !== 6'(exp_cnt) || next_addr_o !== exp_next || err_o !== exp_err) begin
        bad++; $display("FAIL rand%0d_result: got cnt=%0d next=%h err=%b exp cnt=%0d next=%h err=%b",
                        it, dev_count_o, next_addr_o, err_o, exp_cnt, exp_next, exp_err);
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit got, pok; int d;
    clear_cfg();
    present[30] = 1; bmask[30][0] = 32'hFFFF_F000; bmask[30][2] = 32'hFFFF_FFF0;
    build_model();
    run_scan(40, got, pok);
    total++; d = first_diff();
    if (!got || d != -1) begin
      bad++; $display("FAIL busy_start_log: done=%b idx=%0d got=%h exp=%h", got, d, log_at(d), exp_at(d));
    end
  endtask

  task automatic test_handshake();
    bit got, pok, seen; int d;
    clear_cfg();
    present[2] = 1; bmask[2][0] = 32'hFFFF_F000; bmask[2][1] = 32'hFFFF_FF01;
    ack_delay = 5;
    build_model();
    run_scan(-1, got, pok);
    total++; d = first_diff();
    if (!got || d != -1) begin
      bad++; $display("FAIL hs_log: done=%b idx=%0d got=%h exp=%h", got, d, log_at(d), exp_at(d));
    end
    total++;
    if (stab_err != 0 || gap_err != 0) begin
      bad++; $display("FAIL hs_stable: got stab=%0d gap=%0d exp 0/0", stab_err, gap_err);
    end
    // Abort the next scan while BAR0's base write is pending
    @(negedge clk_i); start_i = 1;
    @(negedge clk_i); start_i = 0;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk_i);
      seen = cs_config_o && we_o && adr_o[7:2] == 6'd4 && dat_o == 32'h4000_0000;
    end
    total++; if (!seen) begin bad++; $display("FAIL hs_wrbase_seen: base write not observed"); end
    rst_ni = 0;
    #1;
    total++;
    if ({cs_config_o, we_o, sel_o, adr_o, dat_o} !== '0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL hs_reset_bus: got cs=%b we=%b sel=%h adr=%h dat=%h busy=%b exp 0",
                      cs_config_o, we_o, sel_o, adr_o, dat_o, busy_o);
    end
    total++;
    if (dev_count_o !== 6'd0 || next_addr_o !== BASE || done_o !== 1'b0) begin
      bad++; $display("FAIL hs_reset_status: got cnt=%0d next=%h done=%b exp 0/%h/0",
                      dev_count_o, next_addr_o, done_o, BASE);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    ack_delay = -1;
    @(negedge clk_i);
  endtask

`ifdef PCI32_CFG_ENUM_TIMEOUT_EN
  task automatic test_timeout();
    bit got, pok; int d;
    clear_cfg();
    mute_dev = 0;
    present[1] = 1; bmask[1][0] = 32'hFFFF_FFF0;
    build_model();
    run_scan(-1, got, pok);
    total++; d = first_diff();
    if (!got || d != -1) begin
      bad++; $display("FAIL to_log: done=%b idx=%0d got=%h exp=%h", got, d, log_at(d), exp_at(d));
    end
    total++;
    if (err_o !== 1'b1 || dev_count_o !== 6'd1) begin
      bad++; $display("FAIL to_result: got err=%b cnt=%0d exp err=1 cnt=1", err_o, dev_count_o);
    end
    mute_dev = -1;
  endtask
`endif

  initial begin
    test_reset();
    test_empty_bus();
    test_single_dev();
    test_alignment();
    test_overflow();
    test_random();
    test_busy_ignore();
    test_handshake();
`ifdef PCI32_CFG_ENUM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
